// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the 7-segment display drivers.
// Segment bytes are held in active-high form here: bit0=a ... bit6=g, bit7=dp.
package hex_disp_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_OFF = 8'h00;
  localparam seg_t SEG_DP  = 8'h80;

  // Glyphs for hex digits 0..F, active-high, dp bit clear.
  localparam seg_t SEG_LUT [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  function automatic seg_t seg_glyph(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble/dp/dark to active-high segment byte.
// Polarity inversion is left to the caller.
module hex_seg_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       dark,
  output logic [7:0] seg
);

  // A dark digit shows nothing, including its decimal point.
  always_comb begin
    seg = SEG_OFF;
    if (!dark) begin
      seg = seg_glyph(nib) | (dp ? SEG_DP : SEG_OFF);
    end
  end

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed, double-buffered driver for a DIGITS-wide common-anode
// 7-segment bank with blanking, decimal points, leading-zero suppression
// and selectable output polarity.
//
// Update handshake: upd is a one-cycle strobe that is always accepted
// (there is no ready). Each strobe copies upd_value/upd_dp/upd_blank into
// the shadow register and raises pending; the last strobe before a frame
// boundary wins. At the frame boundary edge the active register takes the
// upd_* inputs directly if upd is high that same cycle, otherwise the
// shadow if pending; pending then drops.
module hex_scan_driver
  import hex_disp_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int REFRESH_DIV     = 50000,
  parameter int SEG_ACTIVE_LOW  = 1,
  parameter int GRID_ACTIVE_LOW = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  upd,
  input  logic [4*DIGITS-1:0]   upd_value,
  input  logic [DIGITS-1:0]     upd_dp,
  input  logic [DIGITS-1:0]     upd_blank,
  input  logic                  zero_suppress,
  output logic                  pending,
  output logic                  frame_tick,
  output logic [7:0]            hex_seg,
  output logic [DIGITS-1:0]     hex_grid
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = $clog2(REFRESH_DIV);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [7:0]        SEG_IDLE  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] GRID_IDLE = (GRID_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [DIV_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    idx;
  logic                div_wrap;
  logic                frame_end;

  logic [4*DIGITS-1:0] shadow_value;
  logic [DIGITS-1:0]   shadow_dp;
  logic [DIGITS-1:0]   shadow_blank;
  logic [4*DIGITS-1:0] active_value;
  logic [DIGITS-1:0]   active_dp;
  logic [DIGITS-1:0]   active_blank;

  logic [DIGITS-1:0]   zs_dark;
  logic                upper_zero;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_dark;
  logic [DIGITS-1:0]   grid_sel;
  logic [7:0]          dec_seg;

  assign div_wrap  = (div_cnt == DIV_LAST);
  assign frame_end = div_wrap && (idx == IDX_LAST);

  // Refresh divider and digit index; idx steps once per REFRESH_DIV cycles.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Shadow capture on upd, shadow/bypass transfer into active at frame end.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      shadow_value <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '1;
      active_value <= '0;
      active_dp    <= '0;
      active_blank <= '1;
      pending      <= 1'b0;
    end else begin
      if (upd) begin
        shadow_value <= upd_value;
        shadow_dp    <= upd_dp;
        shadow_blank <= upd_blank;
        pending      <= 1'b1;
      end
      if (frame_end) begin
        if (upd) begin
          active_value <= upd_value;
          active_dp    <= upd_dp;
          active_blank <= upd_blank;
        end else if (pending) begin
          active_value <= shadow_value;
          active_dp    <= shadow_dp;
          active_blank <= shadow_blank;
        end
        pending <= 1'b0;
      end
    end
  end

  // One-cycle pulse following each frame boundary edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
    end
  end

  // Leading-zero mask: digit i>0 goes dark when it and every higher nibble are zero.
  always_comb begin
    zs_dark    = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (active_value[4*i +: 4] == 4'h0);
      zs_dark[i] = zero_suppress && upper_zero;
    end
  end

  // Select the nibble, dp and darkness of the digit currently being scanned.
  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_dark = 1'b1;
    grid_sel = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib     = active_value[4*i +: 4];
        cur_dp      = active_dp[i];
        cur_dark    = active_blank[i] | zs_dark[i];
        grid_sel[i] = 1'b1;
      end
    end
  end

  hex_seg_decode u_decode (
    .nib  (cur_nib),
    .dp   (cur_dp),
    .dark (cur_dark),
    .seg  (dec_seg)
  );

  // Registered outputs with polarity applied; they trail idx by one cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hex_seg  <= SEG_IDLE;
      hex_grid <= GRID_IDLE;
    end else begin
      hex_seg  <= (SEG_ACTIVE_LOW != 0) ? ~dec_seg : dec_seg;
      hex_grid <= (GRID_ACTIVE_LOW != 0) ? ~grid_sel : grid_sel;
    end
  end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver with DIGITS=4, REFRESH_DIV=4.
// dut_a uses active-low outputs, dut_b the same stimulus with active-high outputs.
module tb_hex_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        upd;
  logic [15:0] upd_value;
  logic [3:0]  upd_dp;
  logic [3:0]  upd_blank;
  logic        zero_suppress;

  logic        pending_a, frame_tick_a;
  logic [7:0]  seg_a;
  logic [3:0]  grid_a;
  logic        pending_b, frame_tick_b;
  logic [7:0]  seg_b;
  logic [3:0]  grid_b;

  int tests = 0;
  int fails = 0;
  int n     = 0;

  // Clock and reset block
  always #5 clk = ~clk;

  hex_scan_driver #(
    .DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .GRID_ACTIVE_LOW(1)
  ) dut_a (
    .Clk(clk), .Reset(reset), .upd(upd), .upd_value(upd_value),
    .upd_dp(upd_dp), .upd_blank(upd_blank), .zero_suppress(zero_suppress),
    .pending(pending_a), .frame_tick(frame_tick_a),
    .hex_seg(seg_a), .hex_grid(grid_a)
  );

  hex_scan_driver #(
    .DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(0), .GRID_ACTIVE_LOW(0)
  ) dut_b (
    .Clk(clk), .Reset(reset), .upd(upd), .upd_value(upd_value),
    .upd_dp(upd_dp), .upd_blank(upd_blank), .zero_suppress(zero_suppress),
    .pending(pending_b), .frame_tick(frame_tick_b),
    .hex_seg(seg_b), .hex_grid(grid_b)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " seg_a"}, {24'h0, seg_a}, 32'hFF);
    chk({tag, " grid_a"}, {28'h0, grid_a}, 32'hF);
    chk({tag, " seg_b"}, {24'h0, seg_b}, 32'h00);
    chk({tag, " grid_b"}, {28'h0, grid_b}, 32'h0);
    chk({tag, " pending_a"}, {31'h0, pending_a}, 32'h0);
    chk({tag, " pending_b"}, {31'h0, pending_b}, 32'h0);
    chk({tag, " frame_tick_a"}, {31'h0, frame_tick_a}, 32'h0);
    chk({tag, " frame_tick_b"}, {31'h0, frame_tick_b}, 32'h0);
  endtask

  // Checks one whole frame; segs holds active-low bytes {d3,d2,d1,d0}.
  // Precondition: n is a multiple of 16 (just after a frame boundary edge).
  task automatic run_frame(input logic [31:0] segs, input string tag);
    int         d;
    logic [3:0] eg;
    logic [7:0] es;
    logic [3:0] egb;
    logic [7:0] esb;
    for (int k = 0; k < 16; k++) begin
      step();
      d   = ((n - 1) / 4) % 4;
      eg  = 4'hF ^ (4'b0001 << d);
      es  = segs[8*d +: 8];
      egb = ~eg;
      esb = ~es;
      chk($sformatf("%s n=%0d grid_a", tag, n), {28'h0, grid_a}, {28'h0, eg});
      chk($sformatf("%s n=%0d seg_a", tag, n), {24'h0, seg_a}, {24'h0, es});
      chk($sformatf("%s n=%0d grid_b", tag, n), {28'h0, grid_b}, {28'h0, egb});
      chk($sformatf("%s n=%0d seg_b", tag, n), {24'h0, seg_b}, {24'h0, esb});
      chk($sformatf("%s n=%0d frame_tick", tag, n), {31'h0, frame_tick_a},
          {31'h0, (n % 16 == 0)});
    end
  endtask

  // Issues one update after pre idle cycles and follows it to the boundary.
  // Precondition: n is a multiple of 16 and pre <= 13.
  task automatic load_frame(input logic [15:0] value, input logic [3:0] dp,
                            input logic [3:0] blank, input int pre, input string tag);
    repeat (pre) step();
    upd_value = value;
    upd_dp    = dp;
    upd_blank = blank;
    upd       = 1'b1;
    step();
    upd       = 1'b0;
    chk($sformatf("%s n=%0d pending", tag, n), {31'h0, pending_a}, 32'h1);
    while (n % 16 != 0) begin
      step();
      if (n % 16 != 0)
        chk($sformatf("%s n=%0d pending", tag, n), {31'h0, pending_a}, 32'h1);
    end
    chk({tag, " pending after boundary"}, {31'h0, pending_a}, 32'h0);
    chk({tag, " frame_tick at boundary"}, {31'h0, frame_tick_a}, 32'h1);
  endtask

  // Directed stimulus
  initial begin
    logic [3:0] exp_pend_k;
    int         d;
    logic [31:0] old_segs;
    logic [7:0]  es;

    reset         = 1'b1;
    upd           = 1'b0;
    upd_value     = 16'h0;
    upd_dp        = 4'h0;
    upd_blank     = 4'h0;
    zero_suppress = 1'b0;

    // Reset held two cycles, then a blank scan frame
    step();
    step();
    chk_idle("reset");
    reset = 1'b0;
    n     = 0;
    run_frame(32'hFFFF_FFFF, "blank_scan");

    // Plain update mid-frame
    load_frame(16'h12AF, 4'h0, 4'h0, 3, "upd_12af");
    run_frame(32'hF9A4_888E, "show_12af");

    // Leading-zero suppression
    zero_suppress = 1'b1;
    load_frame(16'h0070, 4'h0, 4'h0, 0, "upd_0070");
    run_frame(32'hFFFF_F8C0, "show_0070");
    load_frame(16'h0000, 4'h0, 4'h0, 6, "upd_0000");
    run_frame(32'hFFFF_FFC0, "show_0000");

    // Three updates in one frame, the last on the boundary cycle
    old_segs = 32'hFFFF_FFC0;
    for (int k = 1; k <= 16; k++) begin
      upd       = (k == 3) || (k == 8) || (k == 16);
      upd_value = (k == 3) ? 16'h1111 : ((k == 8) ? 16'h2222 : 16'h3333);
      upd_dp    = 4'h0;
      upd_blank = 4'h0;
      step();
      upd = 1'b0;
      d   = ((n - 1) / 4) % 4;
      es  = old_segs[8*d +: 8];
      exp_pend_k = {3'b0, (k >= 3) && (k < 16)};
      chk($sformatf("multi_upd k=%0d seg_a", k), {24'h0, seg_a}, {24'h0, es});
      chk($sformatf("multi_upd k=%0d pending", k), {31'h0, pending_a}, {28'h0, exp_pend_k});
    end
    chk("multi_upd frame_tick", {31'h0, frame_tick_a}, 32'h1);
    run_frame(32'hB0B0_B0B0, "show_3333");

    // Decimal point and blanking, both polarities
    zero_suppress = 1'b0;
    load_frame(16'h5678, 4'b0100, 4'b0001, 5, "upd_dp_blank");
    run_frame(32'h9202_F8FF, "show_dp_blank");

    // Reset mid-frame with an update pending
    upd_value = 16'h9999;
    upd_dp    = 4'h0;
    upd_blank = 4'h0;
    upd       = 1'b1;
    step();
    upd = 1'b0;
    step();
    step();
    chk("mid_reset pending before", {31'h0, pending_a}, 32'h1);
    reset = 1'b1;
    step();
    chk_idle("mid_reset");
    reset = 1'b0;
    n     = 0;
    run_frame(32'hFFFF_FFFF, "after_reset_f0");
    run_frame(32'hFFFF_FFFF, "after_reset_f1");
    zero_suppress = 1'b1;
    load_frame(16'h0001, 4'h0, 4'h0, 2, "upd_0001");
    run_frame(32'hFFFF_FFF9, "show_0001");

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
